// File: rtl/blake2_pkg.sv
// Shared constants for the BLAKE2 G datapath: word widths, rotation amounts
// for the b (64-bit) and s (32-bit) variants, and the iterative controller states.
`timescale 1ns/1ps
package blake2_pkg;

    localparam int W_B  = 64;
    localparam int W_S  = 32;

    localparam int R1_B = 32;
    localparam int R2_B = 24;
    localparam int R3_B = 16;
    localparam int R4_B = 63;

    localparam int R1_S = 16;
    localparam int R2_S = 12;
    localparam int R3_S = 8;
    localparam int R4_S = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        DONE = 2'd2
    } g_state_t;

endpackage

// File: rtl/blake2_g_half.sv
// Combinational BLAKE2 half-step: a+=b+m, d=(d^a)>>>RA, c+=d, b=(b^c)>>>RB.
`timescale 1ns/1ps
module blake2_g_half #(
    parameter int W  = 64,
    parameter int RA = 32,
    parameter int RB = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [W-1:0] m,
    output logic [W-1:0] a_n,
    output logic [W-1:0] b_n,
    output logic [W-1:0] c_n,
    output logic [W-1:0] d_n
);

    function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int r);
        return (v >> r) | (v << (W - r));
    endfunction

    always_comb begin
        a_n = a + b + m;
        d_n = rotr(d ^ a_n, RA);
        c_n = c + d_n;
        b_n = rotr(b ^ c_n, RB);
    end

endmodule

// File: rtl/blake2_g_seq.sv
// Registered, handshaked BLAKE2 G function (W=64 BLAKE2b, W=32 BLAKE2s).
// Iterative 3-state controller by default; define BLAKE2_G_PIPE_EN for a 2-stage pipeline.
`timescale 1ns/1ps
module blake2_g_seq
    import blake2_pkg::*;
#(
    parameter int W  = W_B,
    parameter int R1 = (W == W_S) ? R1_S : R1_B,
    parameter int R2 = (W == W_S) ? R2_S : R2_B,
    parameter int R3 = (W == W_S) ? R3_S : R3_B,
    parameter int R4 = (W == W_S) ? R4_S : R4_B
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic [W-1:0] c_o,
    output logic [W-1:0] d_o
);

    if (!(W == W_B || W == W_S)) begin : g_bad_w
        $error("blake2_g_seq: W must be 32 or 64");
    end
    if (R1 < 1 || R1 > W-1 || R2 < 1 || R2 > W-1 ||
        R3 < 1 || R3 > W-1 || R4 < 1 || R4 > W-1) begin : g_bad_r
        $error("blake2_g_seq: rotation amounts must lie in 1..W-1");
    end

    logic [W-1:0] a1, b1, c1, d1, y_r;
    logic [W-1:0] h1_a, h1_b, h1_c, h1_d;
    logic [W-1:0] h2_a, h2_b, h2_c, h2_d;
    logic         load_1, load_2;

    blake2_g_half #(.W(W), .RA(R1), .RB(R2)) u_half_1 (
        .a(a_i), .b(b_i), .c(c_i), .d(d_i), .m(x_i),
        .a_n(h1_a), .b_n(h1_b), .c_n(h1_c), .d_n(h1_d)
    );

    blake2_g_half #(.W(W), .RA(R3), .RB(R4)) u_half_2 (
        .a(a1), .b(b1), .c(c1), .d(d1), .m(y_r),
        .a_n(h2_a), .b_n(h2_b), .c_n(h2_c), .d_n(h2_d)
    );

`ifdef BLAKE2_G_PIPE_EN
    logic v1, v2, ld1, ld2;

    // stage 2 drains into the consumer; stage 1 may refill whenever stage 2 moves
    assign ld2     = !v2 || ready_i;
    assign ld1     = !v1 || ld2;
    assign ready_o = ld1;
    assign valid_o = v2;
    assign load_1  = ld1 && valid_i;
    assign load_2  = ld2 && v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (ld1) v1 <= valid_i;
            if (ld2) v2 <= v1;
        end
    end
`else
    // state | meaning
    // IDLE  | ready for input; first half-step captured on accept
    // HALF  | second half-step being written to the output registers
    // DONE  | result presented, held until consumed
    g_state_t state, state_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready_o  = 1'b0;
        valid_o  = 1'b0;
        load_1   = 1'b0;
        load_2   = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    load_1   = 1'b1;
                    state_nx = HALF;
                end
            end
            HALF: begin
                load_2   = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1  <= '0;
            b1  <= '0;
            c1  <= '0;
            d1  <= '0;
            y_r <= '0;
            a_o <= '0;
            b_o <= '0;
            c_o <= '0;
            d_o <= '0;
        end else begin
            if (load_1) begin
                a1  <= h1_a;
                b1  <= h1_b;
                c1  <= h1_c;
                d1  <= h1_d;
                y_r <= y_i;
            end
            if (load_2) begin
                a_o <= h2_a;
                b_o <= h2_b;
                c_o <= h2_c;
                d_o <= h2_d;
            end
        end
    end

endmodule

// File: tb/tb_blake2_g_seq.sv
// Scoreboard bench for blake2_g_seq at W=32 (BLAKE2s rotations 16/12/8/7).
`timescale 1ns/1ps
module tb_blake2_g_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i, ready_o, valid_o, ready_i;
    logic [W-1:0] a_i, b_i, c_i, d_i, x_i, y_i;
    logic [W-1:0] a_o, b_o, c_o, d_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [4*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    blake2_g_seq #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i), .x_i(x_i), .y_i(y_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int r);
        return (v >> r) | (v << (W - r));
    endfunction

    function automatic logic [4*W-1:0] g_ref(input logic [W-1:0] a, b, c, d, x, y);
        logic [W-1:0] va, vb, vc, vd;
        va = a; vb = b; vc = c; vd = d;
        va = va + vb + x;  vd = rotr(vd ^ va, 16);
        vc = vc + vd;      vb = rotr(vb ^ vc, 12);
        va = va + vb + y;  vd = rotr(vd ^ va, 8);
        vc = vc + vd;      vb = rotr(vb ^ vc, 7);
        return {va, vb, vc, vd};
    endfunction

    // called at posedge+1; returns at posedge+1 just after the accept edge
    task automatic send(input logic [W-1:0] a, b, c, d, x, y,
                        input logic [4*W-1:0] exp_v, input bit use_exp, input bit rnd);
        bit done;
        done = 0;
        a_i = a; b_i = b; c_i = c; d_i = d; x_i = x; y_i = y;
        valid_i = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (rnd) ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
`ifdef BLAKE2_G_PIPE_EN
            if (rnd && ready_i) chk("ready_o_thru", ready_o, 1'b1);
`endif
            if (ready_o) begin
                done = 1;
                exp_q.push_back(use_exp ? exp_v : g_ref(a, b, c, d, x, y));
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        if (!done) chk("accept_timeout", done, 1'b1);
    endtask

    task automatic drain();
        ready_i = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_result", valid_o, 1'b0);
            else                   chk("result", {a_o, b_o, c_o, d_o}, exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        a_i = '0; b_i = '0; c_i = '0; d_i = '0; x_i = '0; y_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_outputs", {a_o, b_o, c_o, d_o}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_o", ready_o, 1'b1);
        @(posedge clk); #1;

        // all-zero job: latency and ready_o return after consume
        ready_i = 1'b1;
        send('0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("lat_valid_k", valid_o, 1'b0);
        @(negedge clk);
        chk("lat_valid_k1", valid_o, 1'b1);
        @(negedge clk);
        chk("post_consume_ready", ready_o, 1'b1);
        chk("post_consume_valid", valid_o, 1'b0);
        @(posedge clk); #1;

        send(32'h1, '0, '0, '0, '0, '0,
             {32'h00000011, 32'h20220202, 32'h11010100, 32'h11000100}, 1'b1, 1'b0);
        drain();
        send(32'hFFFFFFFF, 32'h1, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        drain();
        send(32'h6A09E667, 32'h510E527F, 32'h3C6EF372, 32'h9B05688C,
             32'h61626300, 32'hDEADBEEF, '0, 1'b0, 1'b0);
        drain();

`ifndef BLAKE2_G_PIPE_EN
        // hold in DONE with ready_i low; extra valid_i pulses must be ignored
        ready_i = 1'b0;
        send($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !valid_o; i++) @(negedge clk);
        chk("stall_reach_done", valid_o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            valid_i = 1'b1;
            a_i = $urandom; b_i = $urandom; x_i = $urandom;
            @(negedge clk);
            chk("stall_valid", valid_o, 1'b1);
            chk("stall_ready", ready_o, 1'b0);
            chk("stall_hold", {a_o, b_o, c_o, d_o}, exp_q[0]);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_ghost_job", valid_o, 1'b0);
        end
        @(posedge clk); #1;
`endif

        // reset while the job is in flight
        ready_i = 1'b1;
        send(32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 32'h4B5A6978,
             32'h11111111, 32'h22222222, '0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_outputs", {a_o, b_o, c_o, d_o}, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", valid_o, 1'b0);
        end
        @(posedge clk); #1;
        send(32'hCAFEBABE, 32'h0BADF00D, 32'h12345678, 32'h87654321,
             32'hA5A5A5A5, 32'h5A5A5A5A, '0, 1'b0, 1'b0);
        drain();

        // random jobs with random consumer stalls
        for (int j = 0; j < 40; j++)
            send($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, '0, 1'b0, 1'b1);
        drain();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/blake2_g_seq.md
Name: blake2_g_seq

Overview:
- Registered, handshaked BLAKE2 mixing function G: takes the four state words a,b,c,d and two message words x,y, and returns the mixed a,b,c,d.
- Generalised over word width: W=64 gives BLAKE2b, W=32 gives BLAKE2s. Rotation amounts derive from W by default and can be overridden.
- Iterative by default: one G half-step per cycle. Optional fully pipelined build.
- Sits between the round scheduler (which supplies the words) and the v[0..15] working-state register file.

Parameters:
- W, 64: word width; only 32 and 64 are legal.
- R1, (W==64 ? 32 : 16): rotation for the first d update.
- R2, (W==64 ? 24 : 12): rotation for the first b update.
- R3, (W==64 ? 16 : 8): rotation for the second d update.
- R4, (W==64 ? 63 : 7): rotation for the second b update.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- valid_i  in  1  input words valid.
- ready_o  out  1  block can accept input.
- a_i, b_i, c_i, d_i  in  W each  input state words.
- x_i, y_i  in  W each  message words.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- a_o, b_o, c_o, d_o  out  W each  mixed state words.

Behaviour:
- Half-step H(a,b,c,d,m,Ra,Rb), computed in order:
  - a' = a+b+m mod 2^W
  - d' = (d^a') rotated right by Ra
  - c' = c+d' mod 2^W
  - b' = (b^c') rotated right by Rb
- G is H(...,x,R1,R2) followed by H(...,y,R3,R4).
- All carries are discarded. Rotation is a right rotate, not a shift.
- Handshakes: an input is accepted on the clk edge where valid_i & ready_o; a result is consumed on the edge where valid_o & ready_i.
- Input words need only be stable on the accept edge. The first half-step is computed combinationally from the inputs and registered together with y_i.
- Iterative FSM, three states:
  - IDLE: ready_o=1, valid_o=0. On accept, register the first half-step result and y, then go to HALF.
  - HALF: ready_o=0. Register the second half-step into the output registers, then go to DONE.
  - DONE: valid_o=1, ready_o=0. Outputs are held stable until ready_i; on consume, go to IDLE.
  - Latency: accept at edge k gives valid_o=1 after edge k+1.
  - Throughput: at most one G per 3 cycles; a new input is never accepted in DONE.
- Reset:
  - State goes to IDLE; valid_o=0; ready_o=1 once reset is low.
  - a_o..d_o and all internal registers are cleared to 0.
  - Reset asserted mid-operation discards the in-flight job; no result is emitted.
- valid_i while ready_o=0 is ignored and the data is not latched. The upstream must hold it.
- Elaboration fails if W is not 32/64 or if any R is outside 1..W-1.

Optional Feature:
- Macro BLAKE2_G_PIPE_EN.
- Defined: two-stage pipeline, stage1 = first half-step, stage2 = second half-step.
  - Per-stage valid bits.
  - stage2 loads when !v2 | ready_i; stage1 loads when !v1 | (stage2 loads).
  - ready_o = !v1 | !v2 | ready_i (combinational).
  - Same 2-edge latency; throughput 1/cycle with no bubbles under continuous ready_i.
- Undefined: the iterative FSM above; pipeline logic is not compiled.
- Port list is identical in both builds.

Decomposition:
- Package blake2_pkg: rotation constants for the b and s variants (R*_B, R*_S), word-width constants (W_B=64, W_S=32), and the FSM state enum (IDLE, HALF, DONE).
- Sub-module blake2_g_half: combinational half-step. Parameters W, RA, RB; inputs a,b,c,d,m; outputs a,b,c,d.
  - Iterative build: two instances, one on the input path and one on the registered path.
  - Pipelined build: one instance per stage.

Test Plan:
- W=32, all inputs 0, accept then ready_i=1 -> valid_o after 2 edges; outputs all 0; ready_o back to 1 the cycle after consume.
- W=32, a=1, b=c=d=x=y=0 -> a_o=0x00000011, b_o=0x20220202, c_o=0x11010100, d_o=0x11000100.
- W=32, a=0xFFFFFFFF, b=1, x=0, c=d=y=0 -> first sum wraps to 0; all outputs match the software model (carry dropped).
- Iterative, ready_i=0 for 5 cycles in DONE -> valid_o and outputs held constant, ready_o=0, valid_i pulses ignored; consume -> IDLE.
- rst pulsed while in HALF -> valid_o=0 and outputs 0 immediately (asynchronous); no result emitted after release; next job correct.
- BLAKE2_G_PIPE_EN, W=64, 100 random jobs, random ready_i stalls -> in-order results matching the BLAKE2b G reference; 1 result/cycle whenever ready_i=1.
